// File: rtl/p12_uart_pkg.sv
// Shared types and constants for the 16x oversampling UART receiver.
package p12_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int unsigned OVERSAMPLE   = 16;
    localparam int unsigned TICK_W       = $clog2(OVERSAMPLE);
    localparam int unsigned TNUM_W       = TICK_W + 1;
    localparam int unsigned SAMPLE_EARLY = 7;
    localparam int unsigned SAMPLE_MID   = 8;
    localparam int unsigned SAMPLE_LATE  = 9;

    // 2-of-3 vote used for every data and stop bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every max(div,1) clocks, restartable.
module uart_baud_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic             reload,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_m1;

    assign div_m1 = (div == '0) ? '0 : div - DIV_W'(1);

    // Down-counter; reload restarts a full period so ticks align to the start edge.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = div_m1;
        end else if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = div_m1;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with 16x oversampling, majority-voted bits and
// valid/overrun/frame-error status toward a single consumer.
module uart_rx_os #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic [DIV_W-1:0]     bauddiv,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 busy
);

    import p12_uart_pkg::*;

    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS + 1);

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e            state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 skip_q, skip_d;
    logic                 s7_q, s7_d, s8_q, s8_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;

    logic                 tick;
    logic                 reload;
    logic                 complete;
    logic                 bit_val;
    logic [TNUM_W-1:0]    tick_num;
    logic [DATA_BITS:0]   shift_tmp;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .div    (bauddiv),
        .reload (reload),
        .tick   (tick)
    );

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // tick_num is the 1-based index of the current tick within the bit.
    assign tick_num  = TNUM_W'(tick_cnt_q) + TNUM_W'(1);
    assign bit_val   = maj3(s7_q, s8_q, rx_sync_q);
    assign shift_tmp = {bit_val, shreg_q};

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        skip_d      = skip_q;
        s7_d        = s7_q;
        s8_d        = s8_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        reload      = 1'b0;
        complete    = 1'b0;

        if (tick && state_q != ST_IDLE) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d    = ST_START;
                    reload     = 1'b1;
                    tick_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick && tick_num == TNUM_W'(SAMPLE_MID)) begin
                    if (!rx_sync_q) begin
                        state_d   = ST_DATA;
                        skip_d    = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                // Entered mid start bit: ignore ticks until the start bit ends.
                if (tick && skip_q) begin
                    if (tick_num == TNUM_W'(OVERSAMPLE)) begin
                        skip_d = 1'b0;
                    end
                end else if (tick) begin
                    if (tick_num == TNUM_W'(SAMPLE_EARLY)) s7_d = rx_sync_q;
                    if (tick_num == TNUM_W'(SAMPLE_MID))   s8_d = rx_sync_q;
                    if (tick_num == TNUM_W'(SAMPLE_LATE)) begin
                        shreg_d = shift_tmp[DATA_BITS:1];
                        if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (tick_num == TNUM_W'(SAMPLE_EARLY)) s7_d = rx_sync_q;
                    if (tick_num == TNUM_W'(SAMPLE_MID))   s8_d = rx_sync_q;
                    if (tick_num == TNUM_W'(SAMPLE_LATE)) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A completing byte takes priority over a same-cycle read.
        if (complete) begin
            data_d      = shreg_q;
            valid_d     = 1'b1;
            frame_err_d = ~bit_val;
            overrun_d   = valid_q & ~rd;
        end else if (rd && valid_q) begin
            valid_d     = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            skip_q      <= 1'b0;
            s7_q        <= 1'b1;
            s8_q        <= 1'b1;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            skip_q      <= skip_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus random frames
// against a frame-level model of the receiver status.
module tb_uart_rx_os;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rxd = 1'b1;
    logic        rd = 1'b0;
    logic [15:0] bauddiv = 16'd4;
    logic [7:0]  data;
    logic        valid, overrun, frame_err, busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ov    = 1'b0;
    logic       m_fe    = 1'b0;

    uart_rx_os #(.DIV_W(16), .DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .bauddiv   (bauddiv),
        .rd        (rd),
        .data      (data),
        .valid     (valid),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".data"},      32'(data),      32'(m_data));
        chk({tag, ".valid"},     32'(valid),     32'(m_valid));
        chk({tag, ".overrun"},   32'(overrun),   32'(m_ov));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
        chk({tag, ".busy"},      32'(busy),      32'(0));
    endtask

    // Drives one 8N1 frame at 16*max(bauddiv,1) clocks per bit. Completion of
    // the stop-bit tick-9 sample lands in the cycle driven at index 153*d+2.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input bit rd_done, input int abort_cyc);
        int         d;
        int         bitlen;
        logic [9:0] bits;
        logic       pre_valid;
        d         = (bauddiv == 16'd0) ? 1 : int'(bauddiv);
        bitlen    = 16 * d;
        bits      = {stop, b, 1'b0};
        pre_valid = m_valid;
        for (int cyc = 0; cyc < 10 * bitlen; cyc++) begin
            @(posedge clk); #1;
            if (abort_cyc > 0 && cyc == abort_cyc) begin
                reset = 1'b0;
                rxd   = 1'b1;
                rd    = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                m_data = 8'h00; m_valid = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
                check_outputs("in_reset");
                reset = 1'b1;
                return;
            end
            if (cyc == 153 * d + 2) chk("lat_pre_valid", 32'(valid), 32'(pre_valid));
            if (cyc == 153 * d + 3) chk("lat_post_valid", 32'(valid), 32'(1));
            rxd = bits[cyc / bitlen];
            rd  = rd_done && (cyc == 153 * d + 2);
        end
        @(posedge clk); #1;
        rxd = 1'b1;
        rd  = 1'b0;
        m_ov    = rd_done ? 1'b0 : m_valid;
        m_valid = 1'b1;
        m_data  = b;
        m_fe    = ~stop;
        repeat (bitlen) @(posedge clk);
        #1;
    endtask

    task automatic do_rd();
        @(posedge clk); #1 rd = 1'b1;
        @(posedge clk); #1 rd = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
        end
    endtask

    task automatic glitch();
        bit saw_busy;
        int t_clear;
        saw_busy = 1'b0;
        t_clear  = -1;
        @(posedge clk); #1 rxd = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 20) rxd = 1'b1;
            if (busy) saw_busy = 1'b1;
            if (saw_busy && !busy && t_clear < 0) t_clear = i;
            @(posedge clk); #1;
        end
        chk("glitch_busy_seen", 32'(saw_busy), 32'(1));
        chk("glitch_idle_in_40", 32'(t_clear >= 0 && t_clear <= 40), 32'(1));
        check_outputs("glitch");
    endtask

    initial begin
        logic [7:0] rb;
        logic       rstop;
        int         mode;

        repeat (4) @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        bauddiv = 16'd4;
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        check_outputs("a5");
        do_rd();
        check_outputs("a5_rd");

        send_frame(8'h3C, 1'b0, 1'b0, 0);
        check_outputs("3c_ferr");
        do_rd();
        check_outputs("3c_rd");

        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        check_outputs("overrun_22");
        send_frame(8'h33, 1'b1, 1'b1, 0);
        check_outputs("rd_collide_33");
        do_rd();
        check_outputs("33_rd");

        glitch();

        send_frame(8'h5A, 1'b1, 1'b0, 4 * 64 + 8);
        repeat (100) @(posedge clk);
        #1;
        check_outputs("after_reset");
        send_frame(8'h81, 1'b1, 1'b0, 0);
        check_outputs("81");
        do_rd();

        bauddiv = 16'd0;
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        check_outputs("div0_ff");
        do_rd();
        send_frame(8'h00, 1'b1, 1'b0, 0);
        check_outputs("div0_00");
        do_rd();
        check_outputs("div0_rd");

        for (int i = 0; i < 16; i++) begin
            bauddiv = 16'($urandom_range(0, 3));
            rb      = 8'($urandom);
            rstop   = ($urandom_range(0, 3) != 0);
            mode    = int'($urandom_range(0, 2));
            send_frame(rb, rstop, mode == 1, 0);
            check_outputs("rand_frame");
            if (mode == 2) begin
                do_rd();
                check_outputs("rand_rd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter DIV_W, default 16, giving the width of the baud divisor input.
REQ-002 SHALL have parameter DATA_BITS, default 8, giving the data bits per frame; the frame format is fixed at 8N1 framing order.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; 0 resets the block.
REQ-005 SHALL have port rxd, input, 1 bit: asynchronous serial line; idle level is 1.
REQ-006 SHALL have port bauddiv, input, DIV_W bits: number of clk cycles per 1/16 bit time; a value of 0 is treated as 1.
REQ-007 SHALL have port rd, input, 1 bit: one-cycle acknowledge that the consumer has taken data.
REQ-008 SHALL have port data, output, DATA_BITS bits: last received byte.
REQ-009 SHALL have port valid, output, 1 bit: data holds an unread byte.
REQ-010 SHALL have port overrun, output, 1 bit: a byte completed while valid was already 1.
REQ-011 SHALL have port frame_err, output, 1 bit: the stop bit of the byte in data sampled 0.
REQ-012 SHALL have port busy, output, 1 bit: 1 in every state except IDLE.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer whose flops reset to 1; all sampling uses the synchronized value.
REQ-014 SHALL generate a 1-cycle tick every max(bauddiv,1) clk cycles, giving 16 ticks per bit.
REQ-015 SHALL reload the tick counter on every IDLE-to-START transition, so that sample phase aligns to the start edge.
REQ-016 SHALL implement states IDLE, START, DATA and STOP.
REQ-017 IDLE: SHALL go to START on the synchronized 1-to-0 transition of rxd.
REQ-018 START: at tick 8 (mid-bit), SHALL go to DATA if the sample is 0, otherwise treat it as a false start, return to IDLE and leave no flags changed.
REQ-019 Each data or stop bit value SHALL be the 2-of-3 majority of the samples taken at ticks 7, 8 and 9 of that bit.
REQ-020 DATA: SHALL shift bits in LSB first; after DATA_BITS bits, SHALL go to STOP.
REQ-021 STOP: at tick 9 of the stop bit, SHALL load data, set valid=1 and set frame_err to the inverse of the stop-bit sample, all in the same cycle, then return to IDLE.
REQ-022 Latency SHALL be as follows: valid rises in the cycle after the tick-9 sample of the stop bit; a new start edge is accepted from the cycle after that.
REQ-023 When a byte completes while valid=1 and rd=0, SHALL overwrite data and set overrun=1.
REQ-024 rd=1 with no completion in the same cycle SHALL clear valid, overrun and frame_err on the next edge.
REQ-025 When rd=1 and a completion occur in the same cycle, the new byte SHALL win: valid stays 1, data and frame_err are updated, and overrun is cleared.
REQ-026 rd while valid=0 SHALL have no effect.
REQ-027 A change of bauddiv mid-frame SHALL take effect at the next tick-counter reload; the frame in progress is not guaranteed to be received correctly.

Reset
REQ-028 With reset=0, SHALL asynchronously force: state IDLE, tick counter 0, synchronizer flops 1, data=0, valid=0, overrun=0, frame_err=0, busy=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte; after release, the block SHALL wait for a fresh 1-to-0 edge.

Structure
REQ-030 Package p12_uart_pkg SHALL hold the state enumeration, the constant OVERSAMPLE=16, and the sample-tick constants 7, 8 and 9.
REQ-031 The tick generator SHALL be the sub-module uart_baud_tick (ports clk, reset, div, reload, tick); the FSM, shift register and flags stay in uart_rx_os.

Verification
REQ-032 Frame 0xA5 with a valid stop bit, bauddiv=4 (64 clk per bit) -> data=0xA5, valid=1, frame_err=0, overrun=0; then rd pulse -> valid=0 on the next edge.
REQ-033 Frame 0x3C with stop bit=0 -> data=0x3C, valid=1, frame_err=1; rd -> frame_err=0.
REQ-034 Frames 0x11 then 0x22 with no rd -> data=0x22, valid=1, overrun=1; rd asserted in the completion cycle of a third frame 0x33 -> data=0x33, valid=1, overrun=0.
REQ-035 A 20-clk low glitch on rxd with bauddiv=4 -> returns to IDLE, valid stays 0, busy=1 then busy=0 within 40 clk.
REQ-036 reset=0 during bit 3 of frame 0x5A, released, then frame 0x81 -> data=0x81, valid=1; 0x5A is never presented.
REQ-037 bauddiv=0 with frames sent at 16 clk per bit: 0xFF then 0x00 -> both received correctly, with one sample per clk.
